// File: rtl/rndgen_pkg.sv
// ============================================================
// rndgen_pkg: LFSR tap settings, feedback helper, checker state
// Rev 1.0
// ============================================================
`default_nettype none

package rndgen_pkg;

  localparam int MAX_N    = 32;
  localparam int MAX_TAPS = 4;
  localparam int IDX_W    = 6;

  typedef logic [IDX_W-1:0] tap_t;

  typedef struct packed {
    tap_t                 TapeNum;
    tap_t [MAX_TAPS-1:0]  FB;
  } RndGenParams_t;

  localparam RndGenParams_t RndGen15 = '{TapeNum: 6'd15, FB: {6'd0, 6'd0, 6'd14, 6'd15}};
  localparam RndGenParams_t RndGen8  = '{TapeNum: 6'd8,  FB: {6'd4, 6'd5, 6'd6, 6'd8}};

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } RndChkState_t;

  // XNOR feedback over the nonzero taps; all-ones is the lock-up state
  function automatic logic rndgen_next(input RndGenParams_t p, input logic [MAX_N:1] sr);
    logic x;
    x = 1'b0;
    for (int i = 0; i < MAX_TAPS; i++) begin
      if (p.FB[i] != '0) x = x ^ sr[p.FB[i]];
    end
    return ~x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rndgen_chk.sv
// ============================================================
// rndgen_chk: self-synchronising serial PRBS checker
// Rev 1.0
// ============================================================
`default_nettype none

module rndgen_chk
  import rndgen_pkg::*;
#(
  parameter RndGenParams_t PARAMS   = RndGen15,
  parameter int            LOCK_CNT = 32,
  parameter int            LOSS_ERR = 8,
  parameter int            LOSS_WIN = 64,
  parameter int            CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             din_valid,
  input  logic             din,
  output logic             locked,
  output logic             err,
  output logic             lost,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int N       = int'(PARAMS.TapeNum);
  localparam int FILL_W  = $clog2(N + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(LOSS_WIN + 1);
  localparam int WERR_W  = $clog2(LOSS_ERR + 1);

  localparam logic [FILL_W-1:0]  c_fill_end = FILL_W'(N);
  localparam logic [MATCH_W-1:0] c_lock_cnt = MATCH_W'(LOCK_CNT);
  localparam logic [WIN_W-1:0]   c_win_last = WIN_W'(LOSS_WIN - 1);
  localparam logic [WERR_W-1:0]  c_loss_err = WERR_W'(LOSS_ERR);

  RndChkState_t       r_state, w_state_nxt;
  logic [N:1]         r_sr, w_sr_nxt;
  logic [FILL_W-1:0]  r_fill, w_fill_nxt;
  logic [MATCH_W-1:0] r_match, w_match_nxt, w_match_inc;
  logic [WIN_W-1:0]   r_win, w_win_nxt;
  logic [WERR_W-1:0]  r_werr, w_werr_nxt, w_werr_inc;
  logic [MAX_N:1]     w_sr_ext;
  logic               w_pred, w_miss, w_stuck, w_err_nxt, w_lost_nxt, w_bit_inc;

  always_comb begin
    w_sr_ext      = '0;
    w_sr_ext[N:1] = r_sr;
  end

  assign w_pred      = rndgen_next(PARAMS, w_sr_ext);
  assign w_miss      = w_pred ^ din;
  assign w_stuck     = &r_sr;
  assign w_match_inc = r_match + 1'b1;
  assign w_werr_inc  = r_werr + WERR_W'(w_miss);

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_fill_nxt  = r_fill;
    w_match_nxt = r_match;
    w_win_nxt   = r_win;
    w_werr_nxt  = r_werr;
    w_err_nxt   = 1'b0;
    w_lost_nxt  = 1'b0;
    w_bit_inc   = 1'b0;
    if (din_valid) begin
      case (r_state)
        SEARCH: begin
          w_sr_nxt = {r_sr[N-1:1], din};
          if (r_fill != c_fill_end) begin
            w_fill_nxt = r_fill + 1'b1;
          end else if (w_stuck || w_miss) begin
            w_match_nxt = '0;
          end else if (w_match_inc == c_lock_cnt) begin
            w_state_nxt = LOCKED;
            w_match_nxt = '0;
            w_win_nxt   = '0;
            w_werr_nxt  = '0;
          end else begin
            w_match_nxt = w_match_inc;
          end
        end
        LOCKED: begin
          // reference free-runs on its own prediction so one bad bit costs one error
          w_sr_nxt  = {r_sr[N-1:1], w_pred};
          w_err_nxt = w_miss;
          w_bit_inc = 1'b1;
          if (w_werr_inc == c_loss_err) begin
            w_lost_nxt  = 1'b1;
            w_state_nxt = SEARCH;
            w_fill_nxt  = '0;
            w_match_nxt = '0;
            w_win_nxt   = '0;
            w_werr_nxt  = '0;
          end else if (r_win == c_win_last) begin
            w_win_nxt  = '0;
            w_werr_nxt = '0;
          end else begin
            w_win_nxt  = r_win + 1'b1;
            w_werr_nxt = w_werr_inc;
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEARCH;
      r_sr    <= '0;
      r_fill  <= '0;
      r_match <= '0;
      r_win   <= '0;
      r_werr  <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      lost    <= 1'b0;
      err_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_fill  <= w_fill_nxt;
      r_match <= w_match_nxt;
      r_win   <= w_win_nxt;
      r_werr  <= w_werr_nxt;
      locked  <= (w_state_nxt == LOCKED);
      err     <= w_err_nxt;
      lost    <= w_lost_nxt;
      if (clr)                          err_cnt <= '0;
      else if (w_err_nxt && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
      if (clr)                          bit_cnt <= '0;
      else if (w_bit_inc && !(&bit_cnt)) bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire
